// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle MIPS subset CPU: opcodes, functs,
// ALU operation and writeback-source enums, and the immediate sign-extender.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_SLL   = 6'd0;
    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_SLT   = 6'd42;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL
    } alu_op_t;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_HI,
        WB_LO
    } wb_sel_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_single_cycle_alu.sv
// Combinational ALU: add/sub wrap around, SLT is a signed compare, SLL shifts b by shamt.
module mips_alu
    import mips_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [4:0]  i_shamt,
    input  alu_op_t     i_op,
    output logic [31:0] o_result,
    output logic        o_zero
);

    always_comb begin
        o_result = 32'd0;  // NOTE: default first so no path through the case leaves o_result held (no latch)
        case (i_op)
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_SLT: o_result = {31'd0, $signed(i_a) < $signed(i_b)};
            ALU_SLL: o_result = i_b << i_shamt;
            default: o_result = 32'd0;
        endcase
    end

    assign o_zero = (o_result == 32'd0);

endmodule

// File: rtl/mips_single_cycle.sv
// Single-cycle MIPS subset CPU: every instruction fetches, executes and commits in one clk.
// Define MIPS_MULTU_EN to build HI/LO and the MULTU/MFHI/MFLO instructions.
module mips_single_cycle
    import mips_pkg::*;
#(
    parameter int IMEM_BYTES = 1024,
    parameter int DMEM_BYTES = 1024
) (
    input logic clk,
    input logic rst
);

    localparam int IA_W = $clog2(IMEM_BYTES);
    localparam int DA_W = $clog2(DMEM_BYTES);

    logic [31:0] pc;
    logic [31:0] instr_ID;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] rfile_wd;

    logic [4:0]      w_rs, w_rt, w_rd, w_shamt, w_wr_addr;
    logic [31:0]     w_sext, w_rs_val, w_rt_val, w_alu_b, w_alu_result, w_load_data;
    logic [31:0]     w_pc_plus4, w_pc_next;
    logic            w_alu_zero, w_use_imm, w_reg_we, w_mem_we, w_branch, w_jump;
    logic [IA_W-1:0] w_iaddr;
    logic [DA_W-1:0] w_daddr;
    alu_op_t         w_alu_op;
    wb_sel_t         w_wb_sel;
`ifdef MIPS_MULTU_EN
    logic            w_mult;
    logic [31:0]     r_hi, r_lo;
`endif

    assign opcode  = instr_ID[31:26];
    assign funct   = instr_ID[5:0];
    assign w_rs    = instr_ID[25:21];
    assign w_rt    = instr_ID[20:16];
    assign w_rd    = instr_ID[15:11];
    assign w_shamt = instr_ID[10:6];
    assign w_sext  = sext16(instr_ID[15:0]);

    // Byte addresses wrap at the memory size through the truncated index.
    assign w_iaddr = pc[IA_W-1:0];

    if (1'b1) begin : InstrMem
        logic [7:0] mem_array [0:IMEM_BYTES-1];
        assign instr_ID = {mem_array[w_iaddr + IA_W'(3)], mem_array[w_iaddr + IA_W'(2)],
                           mem_array[w_iaddr + IA_W'(1)], mem_array[w_iaddr]};
    end

    always_comb begin
        w_alu_op  = ALU_ADD;
        w_wb_sel  = WB_ALU;
        w_use_imm = 1'b0;
        w_reg_we  = 1'b0;
        w_mem_we  = 1'b0;
        w_branch  = 1'b0;
        w_jump    = 1'b0;
        w_wr_addr = w_rt;
`ifdef MIPS_MULTU_EN
        w_mult    = 1'b0;
`endif
        case (opcode)
            OP_RTYPE: begin
                w_wr_addr = w_rd;
                case (funct)
                    FN_SLL: begin w_alu_op = ALU_SLL; w_reg_we = 1'b1; end
                    FN_ADD: begin w_alu_op = ALU_ADD; w_reg_we = 1'b1; end
                    FN_SUB: begin w_alu_op = ALU_SUB; w_reg_we = 1'b1; end
                    FN_AND: begin w_alu_op = ALU_AND; w_reg_we = 1'b1; end
                    FN_OR:  begin w_alu_op = ALU_OR;  w_reg_we = 1'b1; end
                    FN_SLT: begin w_alu_op = ALU_SLT; w_reg_we = 1'b1; end
`ifdef MIPS_MULTU_EN
                    FN_MULTU: w_mult = 1'b1;
                    FN_MFHI: begin w_wb_sel = WB_HI; w_reg_we = 1'b1; end
                    FN_MFLO: begin w_wb_sel = WB_LO; w_reg_we = 1'b1; end
`endif
                    default: ;
                endcase
            end
            OP_ADDIU: begin w_use_imm = 1'b1; w_reg_we = 1'b1; end
            OP_LW:    begin w_use_imm = 1'b1; w_reg_we = 1'b1; w_wb_sel = WB_MEM; end
            OP_SW:    begin w_use_imm = 1'b1; w_mem_we = 1'b1; end
            OP_BEQ:   begin w_alu_op = ALU_SUB; w_branch = 1'b1; end
            OP_J:     w_jump = 1'b1;
            default:  ;
        endcase
    end

    if (1'b1) begin : RegFile
        logic [31:0] file_array [0:31];
        assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : file_array[w_rs];
        assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : file_array[w_rt];

        // NOTE: storage has no reset value so preloaded contents survive rst; rst only blocks the write at an overlapping edge
        always_ff @(posedge clk or negedge rst) begin
            if (rst && w_reg_we && (w_wr_addr != 5'd0)) file_array[w_wr_addr] <= rfile_wd;
        end
    end

    assign w_alu_b = w_use_imm ? w_sext : w_rt_val;

    mips_alu u_alu (
        .i_a      (w_rs_val),
        .i_b      (w_alu_b),
        .i_shamt  (w_shamt),
        .i_op     (w_alu_op),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero)
    );

    assign w_daddr = w_alu_result[DA_W-1:0];

    if (1'b1) begin : DatMem
        logic [7:0] mem_array [0:DMEM_BYTES-1];
        assign w_load_data = {mem_array[w_daddr + DA_W'(3)], mem_array[w_daddr + DA_W'(2)],
                              mem_array[w_daddr + DA_W'(1)], mem_array[w_daddr]};

        always_ff @(posedge clk or negedge rst) begin
            if (rst && w_mem_we) begin
                mem_array[w_daddr]           <= w_rt_val[7:0];
                mem_array[w_daddr + DA_W'(1)] <= w_rt_val[15:8];
                mem_array[w_daddr + DA_W'(2)] <= w_rt_val[23:16];
                mem_array[w_daddr + DA_W'(3)] <= w_rt_val[31:24];
            end
        end
    end

`ifdef MIPS_MULTU_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_mult) begin
            {r_hi, r_lo} <= {32'd0, w_rs_val} * {32'd0, w_rt_val};
        end
    end
`endif

    always_comb begin
        rfile_wd = w_alu_result;
        case (w_wb_sel)
            WB_MEM:  rfile_wd = w_load_data;
`ifdef MIPS_MULTU_EN
            WB_HI:   rfile_wd = r_hi;
            WB_LO:   rfile_wd = r_lo;
`endif
            default: ;
        endcase
    end

    assign w_pc_plus4 = pc + 32'd4;

    always_comb begin
        w_pc_next = w_pc_plus4;
        if (w_jump) w_pc_next = {w_pc_plus4[31:28], instr_ID[25:0], 2'b00};
        else if (w_branch && w_alu_zero) w_pc_next = w_pc_plus4 + {w_sext[29:0], 2'b00};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc <= 32'd0;  // NOTE: non-blocking so every flop samples pre-edge values regardless of block order
        else      pc <= w_pc_next;
    end

endmodule

// File: tb/tb_mips_single_cycle.sv
// Self-checking bench: directed programs plus random programs run in lockstep with an ISA-level model.
module tb_mips_single_cycle;

    localparam int IMEM_BYTES = 1024;
    localparam int DMEM_BYTES = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_single_cycle #(.IMEM_BYTES(IMEM_BYTES), .DMEM_BYTES(DMEM_BYTES)) dut (
        .clk (clk),
        .rst (rst)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Architectural model state
    logic [7:0]  m_imem [IMEM_BYTES];
    logic [7:0]  m_dmem [DMEM_BYTES];
    logic [31:0] m_reg  [32];
    logic [31:0] m_pc, m_hi, m_lo;

    // Effects of the instruction currently at m_pc
    logic        p_we, p_st, p_mult;
    logic [4:0]  p_wr;
    logic [31:0] p_wd, p_addr, p_sdata, p_npc;
    logic [63:0] p_prod;

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(int op, int target);
        return {6'(op), 26'(target)};
    endfunction

    task automatic put_word(input int unsigned addr, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            m_imem[addr + k] = w[8*k +: 8];
            dut.InstrMem.mem_array[addr + k] = w[8*k +: 8];
        end
    endtask

    task automatic set_reg(input int i, input logic [31:0] v);
        m_reg[i] = v;
        dut.RegFile.file_array[i] = v;
    endtask

    task automatic set_dbyte(input int a, input logic [7:0] v);
        m_dmem[a] = v;
        dut.DatMem.mem_array[a] = v;
    endtask

    function automatic logic [31:0] rreg(input logic [4:0] i);
        return (i == 5'd0) ? 32'd0 : m_reg[i];
    endfunction

    task automatic model_eval();
        logic [31:0] ins, a, b, se;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh;
        ins = {m_imem[(m_pc + 3) % IMEM_BYTES], m_imem[(m_pc + 2) % IMEM_BYTES],
               m_imem[(m_pc + 1) % IMEM_BYTES], m_imem[m_pc % IMEM_BYTES]};
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
        sh = ins[10:6];  fn = ins[5:0];
        a  = rreg(rs);   b = rreg(rt);
        se = 32'($signed(ins[15:0]));
        p_we = 1'b0; p_st = 1'b0; p_mult = 1'b0; p_wr = 5'd0; p_wd = 32'd0;
        p_addr = 32'd0; p_sdata = 32'd0; p_prod = 64'd0;
        p_npc = m_pc + 4;
        case (op)
            6'd0: begin
                p_wr = rd;
                case (fn)
                    6'd0:  begin p_we = 1'b1; p_wd = b << sh; end
                    6'd32: begin p_we = 1'b1; p_wd = a + b; end
                    6'd34: begin p_we = 1'b1; p_wd = a - b; end
                    6'd36: begin p_we = 1'b1; p_wd = a & b; end
                    6'd37: begin p_we = 1'b1; p_wd = a | b; end
                    6'd42: begin p_we = 1'b1; p_wd = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
`ifdef MIPS_MULTU_EN
                    6'd25: begin p_mult = 1'b1; p_prod = 64'(a) * 64'(b); end
                    6'd16: begin p_we = 1'b1; p_wd = m_hi; end
                    6'd18: begin p_we = 1'b1; p_wd = m_lo; end
`endif
                    default: ;
                endcase
            end
            6'd9:  begin p_we = 1'b1; p_wr = rt; p_wd = a + se; end
            6'd35: begin
                p_addr = a + se;
                p_we = 1'b1; p_wr = rt;
                p_wd = {m_dmem[(p_addr + 3) % DMEM_BYTES], m_dmem[(p_addr + 2) % DMEM_BYTES],
                        m_dmem[(p_addr + 1) % DMEM_BYTES], m_dmem[p_addr % DMEM_BYTES]};
            end
            6'd43: begin p_st = 1'b1; p_addr = a + se; p_sdata = b; end
            6'd4:  if (a == b) p_npc = m_pc + 4 + (se << 2);
            6'd2:  begin
                logic [31:0] pc4;
                pc4 = m_pc + 4;
                p_npc = {pc4[31:28], ins[25:0], 2'b00};
            end
            default: ;
        endcase
    endtask

    task automatic model_commit();
        if (p_we && p_wr != 5'd0) m_reg[p_wr] = p_wd;
        if (p_st) for (int k = 0; k < 4; k++) m_dmem[(p_addr + k) % DMEM_BYTES] = p_sdata[8*k +: 8];
        if (p_mult) begin m_hi = p_prod[63:32]; m_lo = p_prod[31:0]; end
        m_pc = p_npc;
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_hi = 32'd0; m_lo = 32'd0;
    endtask

    // One instruction in lockstep; outputs sampled on the falling edge.
    task automatic step();
        @(negedge clk);
        model_eval();
        check("pc", dut.pc, m_pc);
        if (p_we) check("rfile_wd", dut.rfile_wd, p_wd);
        @(posedge clk);
        model_commit();
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        int rs, rt, rd;
        rs = $urandom_range(0, 31); rt = $urandom_range(0, 31); rd = $urandom_range(0, 31);
        case ($urandom_range(0, 14))
            0:  return enc_r(rs, rt, rd, 0, 32);
            1:  return enc_r(rs, rt, rd, 0, 34);
            2:  return enc_r(rs, rt, rd, 0, 36);
            3:  return enc_r(rs, rt, rd, 0, 37);
            4:  return enc_r(rs, rt, rd, 0, 42);
            5:  return enc_r(0, rt, rd, $urandom_range(0, 31), 0);
            6:  return enc_r(rs, rt, 0, 0, 25);
            7:  return enc_r(0, 0, rd, 0, ($urandom_range(0, 1) == 0) ? 16 : 18);
            8:  return enc_i(9, rs, rt, $urandom());
            9:  return enc_i(35, rs, rt, $urandom_range(0, 2047) - 1024);
            10: return enc_i(43, rs, rt, $urandom_range(0, 2047) - 1024);
            11: return enc_i(4, rs, ($urandom_range(0, 1) == 0) ? rs : rt, $urandom_range(0, 16) - 8);
            12: return enc_j(2, $urandom_range(0, 255));
            13: return enc_i(9, rs, rt, $urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        // Clean power-up images on both sides
        for (int a = 0; a < IMEM_BYTES; a += 4) put_word(a, 32'd0);
        for (int a = 0; a < DMEM_BYTES; a++) set_dbyte(a, 8'd0);
        for (int i = 0; i < 32; i++) set_reg(i, 32'd0);
        model_reset();
        #1 rst = 1'b0;

        // ---- Program 1: ALU, immediates, memory, shifts, NOPs, MULTU ----
        set_reg(1, 32'd5); set_reg(2, 32'd3); set_reg(5, 32'd7);
        set_reg(8, 32'hDEADBEEF); set_reg(9, 32'hDEADBEEF);
        put_word(32'h00, enc_r(1, 2, 3, 0, 32));
        put_word(32'h04, enc_r(1, 2, 10, 0, 34));
        put_word(32'h08, enc_r(1, 2, 11, 0, 36));
        put_word(32'h0C, enc_r(1, 2, 12, 0, 37));
        put_word(32'h10, enc_r(2, 1, 4, 0, 42));
        put_word(32'h14, enc_i(9, 0, 6, 16'hFFFF));
        put_word(32'h18, enc_i(43, 0, 6, 4));
        put_word(32'h1C, enc_i(35, 0, 7, 4));
        put_word(32'h20, enc_i(9, 0, 0, 5));
        put_word(32'h24, enc_i(9, 0, 14, 1));
        put_word(32'h28, enc_r(0, 14, 13, 4, 0));
        put_word(32'h2C, enc_i(9, 0, 17, 16'hFFFF));
        put_word(32'h30, enc_r(17, 14, 18, 0, 42));
        put_word(32'h34, 32'h0000_0000);
        put_word(32'h38, 32'hFC00_0000);
        put_word(32'h3C, enc_i(9, 0, 15, 16'hFFFF));
        put_word(32'h40, enc_i(9, 0, 16, 2));
        put_word(32'h44, enc_r(15, 16, 0, 0, 25));
        put_word(32'h48, enc_r(0, 0, 8, 0, 16));
        put_word(32'h4C, enc_r(0, 0, 9, 0, 18));
        put_word(32'h50, enc_i(9, 0, 19, 16'h0123));

        @(posedge clk); #1;
        check("reset_pc", dut.pc, 32'd0);
        @(posedge clk); #1;
        check("reset_pc_held", dut.pc, 32'd0);
        rst = 1'b1;
        #2 check("add_wd", dut.rfile_wd, 32'd8);
        step();
        check("pc_after_first_edge", dut.pc, 32'd4);
        for (int n = 1; n < 20; n++) step();

        check("add", dut.RegFile.file_array[3], 32'd8);
        check("sub", dut.RegFile.file_array[10], 32'd2);
        check("and", dut.RegFile.file_array[11], 32'd1);
        check("or", dut.RegFile.file_array[12], 32'd7);
        check("slt", dut.RegFile.file_array[4], 32'd1);
        check("addiu_sext", dut.RegFile.file_array[6], 32'hFFFF_FFFF);
        for (int a = 4; a < 8; a++) check("sw_byte", {24'd0, dut.DatMem.mem_array[a]}, 32'hFF);
        check("lw", dut.RegFile.file_array[7], 32'hFFFF_FFFF);
        check("zero_reg_read", dut.RegFile.file_array[14], 32'd1);
        check("sll", dut.RegFile.file_array[13], 32'd16);
        check("slt_neg", dut.RegFile.file_array[18], 32'd1);
        check("preload_kept", dut.RegFile.file_array[5], 32'd7);
`ifdef MIPS_MULTU_EN
        check("mfhi", dut.RegFile.file_array[8], 32'd1);
        check("mflo", dut.RegFile.file_array[9], 32'hFFFF_FFFE);
`else
        check("mfhi_absent", dut.RegFile.file_array[8], 32'hDEADBEEF);
        check("mflo_absent", dut.RegFile.file_array[9], 32'hDEADBEEF);
`endif

        // ---- Mid-run reset while ADDIU $19 is pending ----
        @(negedge clk);
        model_eval();
        check("pc_before_reset", dut.pc, 32'h50);
        #1 rst = 1'b0;
        #1 check("async_reset_pc", dut.pc, 32'd0);
        @(posedge clk); #1;
        model_reset();
        check("reset_suppresses_write", dut.RegFile.file_array[19], 32'd0);
        check("reset_keeps_regs", dut.RegFile.file_array[5], 32'd7);
        check("reset_pc_after_edge", dut.pc, 32'd0);

        // ---- Program 2: branches and jump ----
        for (int a = 0; a < 32'h60; a += 4) put_word(a, 32'd0);
        put_word(32'h10, enc_i(4, 1, 1, 2));
        put_word(32'h14, enc_i(9, 0, 20, 16'h55));
        put_word(32'h18, enc_i(9, 0, 20, 16'h55));
        put_word(32'h1C, enc_i(4, 1, 2, 5));
        put_word(32'h20, enc_j(2, 32'h10));
        rst = 1'b1;
        for (int n = 0; n < 5; n++) step();
        check("beq_taken", dut.pc, 32'h1C);
        step();
        check("beq_not_taken", dut.pc, 32'h20);
        step();
        check("jump", dut.pc, 32'h40);
        step();
        check("branch_skipped", dut.RegFile.file_array[20], 32'd0);

        // ---- Program 3: random programs in lockstep with the model ----
        for (int pass = 0; pass < 3; pass++) begin
            @(negedge clk);
            rst = 1'b0;
            #1 check("rand_reset_pc", dut.pc, 32'd0);
            model_reset();
            for (int i = 1; i < 32; i++)
                set_reg(i, ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 4)) : $urandom());
            for (int a = 0; a < DMEM_BYTES; a++) set_dbyte(a, 8'($urandom()));
            for (int a = 0; a < IMEM_BYTES; a += 4) put_word(a, rand_instr());
            @(posedge clk); #1;
            rst = 1'b1;
            for (int n = 0; n < 600; n++) step();
            for (int i = 1; i < 32; i++) check("rand_reg", dut.RegFile.file_array[i], m_reg[i]);
            for (int a = 0; a < DMEM_BYTES; a++)
                check("rand_dmem", {24'd0, dut.DatMem.mem_array[a]}, {24'd0, m_dmem[a]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
